// File: rtl/instruction_fetch_pkg.sv
// Shared constants, types and helpers for the instruction fetch unit.
// Holds the default reset PC, buffer depth and FSM encodings.
package instruction_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [1:0]  FIFO_DEPTH       = 2'd2;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  // Sequential fetch address; natural 32-bit overflow gives the required wrap.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of redirect, program-memory and decode-side signals around the fetch unit.
// The fetch unit uses the slave view; its environment uses the master view.
interface instruction_fetch_if;

  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] or_pc;
  logic        or_instruction_request;
  logic [31:0] i_instruction;
  logic        i_ack;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        i_ready;
  logic        o_misaligned;

  modport master (
    output i_redirect, i_redirect_pc, i_instruction, i_ack, i_ready,
    input  or_pc, or_instruction_request, o_valid, o_instruction, o_pc, o_misaligned
  );

  modport slave (
    input  i_redirect, i_redirect_pc, i_instruction, i_ack, i_ready,
    output or_pc, or_instruction_request, o_valid, o_instruction, o_pc, o_misaligned
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Two-entry {pc, instruction} buffer with push, pop, flush and an occupancy count.
// Flush and reset both empty the buffer; stored data is never cleared.
import instruction_fetch_pkg::*;

module fetch_fifo (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [0:1];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != FIFO_DEPTH) || w_do_pop);

  // Storage write, kept out of the reset domain so it maps onto plain flops/RAM.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues sequential fetches, buffers two responses, handles redirects.
// Define FETCH_MISALIGN_TRAP_EN to trap (HALT) on misaligned redirects instead of aligning them.
import instruction_fetch_pkg::*;

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic                i_clk,
  input logic                i_rst,
  instruction_fetch_if.slave bus
);

  fetch_state_e r_state;
  logic [31:0]  r_fetch_pc;
  logic         r_request;
  logic         r_misaligned;

  logic [31:0]  w_redirect_target;
  logic         w_redirect_bad;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_count;
  logic [1:0]   w_count_next;
  fetch_entry_t w_head;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_redirect_target = bus.i_redirect_pc;
  assign w_redirect_bad    = (bus.i_redirect_pc[1:0] != 2'b00);
`else
  assign w_redirect_target = bus.i_redirect_pc & 32'hFFFF_FFFC;
  assign w_redirect_bad    = 1'b0;
`endif

  // A redirect kills any same-cycle response or pop.
  assign w_push = r_request && bus.i_ack && !bus.i_redirect;
  assign w_pop  = bus.o_valid && bus.i_ready && !bus.i_redirect;

  // Occupancy after this edge, used to decide whether the next fetch fits.
  always_comb begin
    w_count_next = w_count;
    if (bus.i_redirect) begin
      w_count_next = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = w_count + 2'd1;
        2'b01:   w_count_next = w_count - 2'd1;
        default: w_count_next = w_count;
      endcase
    end
  end

  // Fetch FSM with its registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_RUN;
      r_fetch_pc   <= RESET_PC;
      r_request    <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (bus.i_redirect) begin
      r_fetch_pc <= w_redirect_target;
      r_request  <= 1'b0;
      if (w_redirect_bad) begin
        r_state      <= ST_HALT;
        r_misaligned <= 1'b1;
      end else begin
        r_state      <= ST_RUN;
        r_misaligned <= 1'b0;
      end
    end else begin
      if (w_push) r_fetch_pc <= pc_inc(r_fetch_pc);
      r_request <= (r_state == ST_RUN) && (w_count_next < FIFO_DEPTH);
    end
  end

  fetch_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.i_redirect),
    .i_data  ({r_fetch_pc, bus.i_instruction}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.or_pc                  = r_fetch_pc;
  assign bus.or_instruction_request = r_request;
  assign bus.o_misaligned           = r_misaligned;
  assign bus.o_valid                = (w_count != 2'd0);
  assign bus.o_pc                   = w_head.pc;
  assign bus.o_instruction          = w_head.insn;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with an always-acking program memory.
// Memory returns pc ^ 32'hDEAD_BEEF so each instruction word identifies its address.
module tb_instruction_fetch;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction

  assign bus.i_instruction = mem_word(bus.or_pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head_is(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    check({tag, "_pc"}, bus.o_pc, pc);
    check({tag, "_insn"}, bus.o_instruction, mem_word(pc));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    bus.i_ack         = 1'b1;
    bus.i_ready       = 1'b1;
    tick();
    tick();
    check("rst_or_pc", bus.or_pc, 32'h0);
    check("rst_req", 32'(bus.or_instruction_request), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_misaligned", 32'(bus.o_misaligned), 32'd0);

    // Streaming: or_pc 0,4,8... with the head trailing by one cycle.
    rst = 1'b0;
    tick();
    check("first_req", 32'(bus.or_instruction_request), 32'd1);
    check("first_or_pc", bus.or_pc, 32'h0);
    check("first_valid", 32'(bus.o_valid), 32'd0);
    tick();
    check("lat_or_pc", bus.or_pc, 32'h4);
    head_is("lat", 32'h0);
    for (int n = 3; n <= 7; n++) begin
      tick();
      check("stream_or_pc", bus.or_pc, 32'(4 * (n - 1)));
      head_is("stream", 32'(4 * (n - 2)));
    end

    // Backpressure from reset: buffer fills with 0x0 and 0x4, then drains in order.
    rst = 1'b1;
    bus.i_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    check("full_req", 32'(bus.or_instruction_request), 32'd0);
    check("full_or_pc", bus.or_pc, 32'h8);
    head_is("full_head", 32'h0);
    bus.i_ready = 1'b1;
    tick();
    head_is("drain0", 32'h4);
    check("drain_req", 32'(bus.or_instruction_request), 32'd1);
    tick();
    head_is("drain1", 32'h8);
    check("resume_or_pc", bus.or_pc, 32'hC);

    // Refill to two entries, then redirect with ack and ready both high.
    bus.i_ready = 1'b0;
    tick();
    head_is("pre_redir", 32'h8);
    check("pre_redir_req", 32'(bus.or_instruction_request), 32'd0);
    bus.i_ready       = 1'b1;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0100;
    tick();
    bus.i_redirect = 1'b0;
    check("redir_valid", 32'(bus.o_valid), 32'd0);
    check("redir_or_pc", bus.or_pc, 32'h100);
    check("redir_req", 32'(bus.or_instruction_request), 32'd0);
    tick();
    check("redir_valid2", 32'(bus.o_valid), 32'd0);
    check("redir_req2", 32'(bus.or_instruction_request), 32'd1);
    tick();
    head_is("redir_head", 32'h100);

    // Address wrap at the top of the 32-bit space.
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.i_redirect = 1'b0;
    tick();
    tick();
    check("wrap_or_pc_fffc", bus.or_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_or_pc_0", bus.or_pc, 32'h0000_0000);
    head_is("wrap_head", 32'hFFFF_FFFC);
    tick();
    head_is("wrap_head0", 32'h0000_0000);

    // Misaligned redirect.
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0102;
    tick();
    bus.i_redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_flag", 32'(bus.o_misaligned), 32'd1);
    check("mis_valid", 32'(bus.o_valid), 32'd0);
    tick();
    tick();
    check("halt_req", 32'(bus.or_instruction_request), 32'd0);
    check("halt_valid", 32'(bus.o_valid), 32'd0);
    check("halt_flag", 32'(bus.o_misaligned), 32'd1);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0200;
    tick();
    bus.i_redirect = 1'b0;
    check("unhalt_flag", 32'(bus.o_misaligned), 32'd0);
    check("unhalt_or_pc", bus.or_pc, 32'h200);
    tick();
    check("unhalt_req", 32'(bus.or_instruction_request), 32'd1);
    tick();
    head_is("unhalt_head", 32'h200);
`else
    check("align_flag", 32'(bus.o_misaligned), 32'd0);
    check("align_or_pc", bus.or_pc, 32'h100);
    tick();
    check("align_req", 32'(bus.or_instruction_request), 32'd1);
    tick();
    head_is("align_head", 32'h100);
`endif

    // Asynchronous reset while one entry is buffered and a request is out.
    check("pre_rst_req", 32'(bus.or_instruction_request), 32'd1);
    rst = 1'b1;
    #1;
    check("async_valid", 32'(bus.o_valid), 32'd0);
    check("async_req", 32'(bus.or_instruction_request), 32'd0);
    check("async_or_pc", bus.or_pc, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("restart_req", 32'(bus.or_instruction_request), 32'd1);
    check("restart_or_pc", bus.or_pc, 32'h0);
    tick();
    head_is("restart_head", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
